// File: rtl/instruction_issuer.sv
// Byte-stream to 32-bit instruction packer, FIFO and issue FSM for the core.
// Ports: clock_in/reset_n_in (sync, active-low), byte_valid_in/byte_data_in/
// byte_ready_out host handshake, run_in/step_in issue control,
// current_instruction_out/instruction_valid_out to core, fifo_count_out,
// stall_out. Optional single-step issue: define ISSUER_STEP_EN.
module instruction_issuer #(
  parameter int          FIFO_DEPTH      = 8,
  parameter int          SETTLE_CYCLES   = 2,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h000000FF
) (
  input  logic                          clock_in,
  input  logic                          reset_n_in,
  input  logic                          byte_valid_in,
  input  logic [7:0]                    byte_data_in,
  output logic                          byte_ready_out,
  input  logic                          run_in,
  input  logic                          step_in,
  output logic [31:0]                   current_instruction_out,
  output logic                          instruction_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          stall_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SLOAD =
    (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_STALL
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            stall_q, stall_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     part_q, part_d;
  logic            step_q, step_d;
  logic [31:0]     mem_q [FIFO_DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic            have;
  logic            step_go;
  logic            stall_op;
  logic [31:0]     push_word;

  assign byte_ready_out = reset_n_in && (cnt_q < DEPTH_C);
  assign accept         = byte_valid_in && byte_ready_out;
  assign push           = accept && (bcnt_q == 2'd3);
  assign push_word      = {byte_data_in, part_q};
  assign have           = (cnt_q != '0);

`ifdef ISSUER_STEP_EN
  // Rising edge of step_in, honoured only when not running.
  assign step_d  = step_in;
  assign step_go = step_in && !step_q && !run_in;
`else
  logic unused_step;
  assign unused_step = step_in;
  assign step_d      = 1'b0;
  assign step_go     = 1'b0;
`endif

  // Tensor register file writes need settle time.
  always_comb begin
    stall_op = 1'b0;
    if (SETTLE_CYCLES > 0) begin
      stall_op = (instr_q[7:0] == 8'h06) || (instr_q[7:0] == 8'h07) ||
                 (instr_q[7:0] == 8'h0C) || (instr_q[7:0] == 8'h0D);
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    part_d = part_q;
    if (accept) begin
      bcnt_d = bcnt_q + 2'd1;
      unique case (bcnt_q)
        2'd0:    part_d[7:0]   = byte_data_in;
        2'd1:    part_d[15:8]  = byte_data_in;
        2'd2:    part_d[23:16] = byte_data_in;
        default: part_d        = part_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = NOP_INSTRUCTION;
    valid_d = 1'b0;
    stall_d = stall_q;
    scnt_d  = scnt_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((run_in || step_go) && have) begin
          pop     = 1'b1;
          instr_d = mem_q[rd_q];
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stall_op) begin
          scnt_d  = SLOAD;
          stall_d = 1'b1;
          state_d = S_STALL;
        end else if (run_in && have) begin
          pop     = 1'b1;
          instr_d = mem_q[rd_q];
          valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STALL: begin
        if (scnt_q == '0) begin
          stall_d = 1'b0;
          if (run_in && have) begin
            pop     = 1'b1;
            instr_d = mem_q[rd_q];
            valid_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      instr_q <= NOP_INSTRUCTION;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      scnt_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      bcnt_q  <= 2'd0;
      part_q  <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      scnt_q  <= scnt_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      bcnt_q  <= bcnt_d;
      part_q  <= part_d;
      step_q  <= step_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clock_in) begin
    if (push) begin
      mem_q[wr_q] <= push_word;
    end
  end

  assign current_instruction_out = instr_q;
  assign instruction_valid_out   = valid_q;
  assign fifo_count_out          = cnt_q;
  assign stall_out               = stall_q;

endmodule
